pong_btn_debounce: RTL

Input conditioner for the Pong paddle buttons, placed directly upstream of `pong_top`. It synchronises the raw `btn[1:0]` pins to `clk` and debounces each bit with a per-channel FSM. It produces clean levels, which replace the raw `btn` fed to the game FSM and `pong_graph`. It also produces one-cycle press ticks, so "button pressed" events are counted once per physical press.

---
 rtl/pong_btn_pkg.sv | 24 ++
 rtl/pong_btn_db_ch.sv | 121 ++++++++++++
 rtl/pong_btn_debounce.sv | 41 ++++
 3 files changed

// File: rtl/pong_btn_pkg.sv
// Shared definitions for the Pong button conditioner: FSM state codes,
// default timing constants and a constant-width helper.
package pong_btn_pkg;

    localparam logic [1:0] ZERO  = 2'd0;
    localparam logic [1:0] WAIT1 = 2'd1;
    localparam logic [1:0] ONE   = 2'd2;
    localparam logic [1:0] WAIT0 = 2'd3;

    localparam int DB_CYCLES_DEF     = 1_000_000;
    localparam int REPEAT_DELAY_DEF  = 25_000_000;
    localparam int REPEAT_PERIOD_DEF = 5_000_000;

    // Bits needed to hold value-1; used for counter widths at elaboration.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pong_btn_db_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM and press tick.
// Optional auto-repeat is compiled in with PONG_BTN_AUTOREPEAT_EN.
module pong_btn_db_ch
    import pong_btn_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF
`ifdef PONG_BTN_AUTOREPEAT_EN
   ,parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF
   ,parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic tick
);

    localparam int            CW       = clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DB_CYCLES - 1);

    logic          s1, s2;
    logic [1:0]    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          press;
    logic          rpt_hit;

    // NOTE: non-blocking assignments make s2 take the old s1, giving two real flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ZERO;
            cnt   <= '0;
            tick  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            tick  <= press | rpt_hit;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        press      = 1'b0;
        case (state)
            ZERO: begin
                if (s2) begin
                    state_next = WAIT1;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!s2) begin
                    state_next = ZERO;
                end else if (cnt == '0) begin
                    state_next = ONE;
                    press      = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ONE: begin
                if (!s2) begin
                    state_next = WAIT0;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT0: begin
                if (s2) begin
                    state_next = ONE;
                end else if (cnt == '0) begin
                    state_next = ZERO;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = ZERO;
        endcase
    end

    always_comb begin
        db = (state == ONE) || (state == WAIT0);
    end

`ifdef PONG_BTN_AUTOREPEAT_EN
    localparam int RW = (clog2(REPEAT_DELAY) < 1) ? 1 : clog2(REPEAT_DELAY);

    logic [RW-1:0] rpt_cnt;
    logic          holding;

    assign holding = (state == ONE) && s2;
    assign rpt_hit = holding && (rpt_cnt == RW'(REPEAT_DELAY - 1));

    // After a hit the counter restarts part-way so the next hit is REPEAT_PERIOD later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_cnt <= '0;
        end else if (!holding) begin
            rpt_cnt <= '0;
        end else if (rpt_hit) begin
            rpt_cnt <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

endmodule

// File: rtl/pong_btn_debounce.sv
// Debounced paddle buttons for pong_top: N_BTN independent channels plus
// any-level / any-tick summaries. Auto-repeat via PONG_BTN_AUTOREPEAT_EN.
module pong_btn_debounce
    import pong_btn_pkg::*;
#(
    parameter int N_BTN         = 2,
    parameter int DB_CYCLES     = DB_CYCLES_DEF
`ifdef PONG_BTN_AUTOREPEAT_EN
   ,parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF
   ,parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_tick,
    output logic             btn_any,
    output logic             tick_any
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        pong_btn_db_ch #(
            .DB_CYCLES    (DB_CYCLES)
`ifdef PONG_BTN_AUTOREPEAT_EN
           ,.REPEAT_DELAY (REPEAT_DELAY)
           ,.REPEAT_PERIOD(REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .raw  (btn_raw[i]),
            .db   (btn_db[i]),
            .tick (btn_tick[i])
        );
    end

    assign btn_any  = |btn_db;
    assign tick_any = |btn_tick;

endmodule
